// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub.
// master drives operands and out_ready; slave (the adder) drives in_ready and results.
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             c_in;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, in1, in2, c_in, op, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, in1, in2, c_in, op, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined 4-bit-group carry-lookahead add/sub, STAGES-cycle latency; CLA_PIPE_SAT_EN enables signed saturation.
// Backpressure: the whole pipe holds while a result is unconsumed; in_ready = (~out_valid | out_ready) & ~rst.
module cla_pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    cla_pipe_addsub_if.slave   bus
);
    // WIDTH must be a multiple of 4 and WIDTH/4 a multiple of STAGES.
    localparam int GPS = WIDTH / (4 * STAGES);
    localparam int L   = STAGES - 1;

    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1, c2, c3, c4;
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c4, p ^ {c3, c2, c1, ci}};
    endfunction

    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_cy  [STAGES];
    logic             r_ovf;
    logic             r_zero;

    logic             w_src_v [STAGES];
    logic [WIDTH-1:0] w_src_a [STAGES];
    logic [WIDTH-1:0] w_src_b [STAGES];
    logic [WIDTH-1:0] w_src_s [STAGES];
    logic             w_src_c [STAGES];
    logic [WIDTH-1:0] w_sum   [STAGES];
    logic             w_cy    [STAGES];
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_zero;
    logic             w_en;

    assign w_en = ~r_vld[L] | bus.out_ready;

    always_comb begin
        // Subtract is folded in at entry: operand b inverted, carry-in forced to 1.
        w_src_v[0] = bus.in_valid;
        w_src_a[0] = bus.in1;
        w_src_b[0] = bus.op ? ~bus.in2 : bus.in2;
        w_src_c[0] = bus.op | bus.c_in;
        w_src_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_src_v[k] = r_vld[k-1];
            w_src_a[k] = r_a[k-1];
            w_src_b[k] = r_b[k-1];
            w_src_c[k] = r_cy[k-1];
            w_src_s[k] = r_sum[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            w_sum[k] = w_src_s[k];
            w_cy[k]  = w_src_c[k];
            for (int g = 0; g < GPS; g++) begin
                {w_cy[k], w_sum[k][(k*GPS+g)*4 +: 4]} =
                    cla4(w_src_a[k][(k*GPS+g)*4 +: 4], w_src_b[k][(k*GPS+g)*4 +: 4], w_cy[k]);
            end
        end

        w_ovf = (w_src_a[L][WIDTH-1] == w_src_b[L][WIDTH-1]) &&
                (w_sum[L][WIDTH-1] != w_src_a[L][WIDTH-1]);
`ifdef CLA_PIPE_SAT_EN
        if (w_ovf) begin
            w_res = w_src_a[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            w_res = w_sum[L];
        end
`else
        w_res = w_sum[L];
`endif
        w_zero = (w_res == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_cy[k]  <= 1'b0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_src_v[k];
                r_a[k]   <= w_src_a[k];
                r_b[k]   <= w_src_b[k];
                r_sum[k] <= w_sum[k];
                r_cy[k]  <= w_cy[k];
            end
            r_sum[L] <= w_res;
            r_ovf    <= w_ovf;
            r_zero   <= w_zero;
        end
    end

    assign bus.in_ready  = w_en & ~rst;
    assign bus.out_valid = r_vld[L];
    assign bus.sum       = r_sum[L];
    assign bus.c_out     = r_cy[L];
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub (WIDTH=32, STAGES=2): vector table, streaming, backpressure,
// random traffic and reset-with-ops-in-flight, all checked through an expected-result queue.
module tb_cla_pipe_addsub;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         op;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    cla_pipe_addsub_if #(.WIDTH(W)) bus();

    cla_pipe_addsub #(.WIDTH(W), .STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_pop = 0;
    vec_t exp_q[$];
    int   pop_cyc[$];
    logic held_pending = 1'b0;
    logic [W+3:0] held;
    vec_t mon_e;
    logic rnd_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Independent reference: signed/unsigned arithmetic on 64-bit integers.
    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic op);
        vec_t        r;
        longint      s;
        logic [63:0] u;
        s = longint'($signed(a)) + (op ? -longint'($signed(b)) : longint'($signed(b)))
          + (op ? 64'sd0 : longint'({63'd0, cin}));
        u = {32'd0, a} + (op ? ({32'd0, ~b} + 64'd1) : ({32'd0, b} + {63'd0, cin}));
        r.a    = a;
        r.b    = b;
        r.cin  = cin;
        r.op   = op;
        r.cout = u[W];
        r.sum  = u[W-1:0];
        r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef CLA_PIPE_SAT_EN
        if (s > 64'sd2147483647)  r.sum = 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) r.sum = 32'h8000_0000;
`endif
        r.zero = (r.sum == '0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            held_pending = 1'b0;
        end else begin
            if (held_pending) begin
                chk("hold", 64'({bus.out_valid, bus.sum, bus.c_out, bus.ovf, bus.zero}), 64'(held));
                held_pending = 1'b0;
            end
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    chk("result_avail", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("result", 64'({bus.sum, bus.c_out, bus.ovf, bus.zero}),
                            64'({mon_e.sum, mon_e.cout, mon_e.ovf, mon_e.zero}));
                    end
                    n_pop++;
                    pop_cyc.push_back(cyc);
                end else begin
                    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    held = {1'b1, bus.sum, bus.c_out, bus.ovf, bus.zero};
                    held_pending = 1'b1;
                end
            end
        end
    end

    task automatic send(input vec_t v);
        int t;
        bus.in1      = v.a;
        bus.in2      = v.b;
        bus.c_in     = v.cin;
        bus.op       = v.op;
        bus.in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        vec_t v;
        int   n0;

        // {a, b, cin, op, sum, cout, ovf, zero}
        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
`ifdef CLA_PIPE_SAT_EN
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
`else
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
`endif
        tbl[5] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{32'h0000_0010, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_000F, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.c_in      = 1'b0;
        bus.op        = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_outputs", 64'({bus.sum, bus.c_out, bus.ovf, bus.zero}), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

        // First vector: result must appear after the second edge counting the accept edge.
        send(tbl[0]);
        chk("lat_edge1_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge2_out_valid", 64'(bus.out_valid), 64'd1);
        for (int i = 1; i < 10; i++) send(tbl[i]);
        drain();

        // Back-to-back stream i + 3i.
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            v = '{W'(i), W'(3 * i), 1'b0, 1'b0, W'(4 * i), 1'b0, 1'b0, (i == 0)};
            send(v);
        end
        drain();
        chk("stream_count", 64'(pop_cyc.size()), 64'd8);
        for (int i = 1; i < 8 && i < pop_cyc.size(); i++)
            chk("stream_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);

        // Backpressure: out_ready low for three cycles mid-stream.
        n0 = n_pop;
        fork
            begin
                for (int i = 0; i < 8; i++) send(mk(W'(32'h100 * i + 5), W'(32'hFFFF_FF00 + i), 1'b0, i[0]));
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                bus.out_ready = 1'b0;
                #1;
                chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
                repeat (3) @(posedge clk);
                #2;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 64'(n_pop - n0), 64'd8);

        // Random traffic with random gaps and random out_ready.
        n0 = n_pop;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [W-1:0] ra;
                    logic [W-1:0] rb;
                    ra = (i % 5 == 0) ? 32'h7FFF_FFFF : $urandom;
                    rb = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
                    send(mk(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #2;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
        chk("rand_count", 64'(n_pop - n0), 64'd40);

        // Reset with two operations in flight; neither may ever be consumed.
        bus.out_ready = 1'b0;
        send(mk(32'h0000_0AAA, 32'h0000_0111, 1'b0, 1'b0));
        send(mk(32'h0000_0BBB, 32'h0000_0222, 1'b0, 1'b0));
        chk("flight_out_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        n0 = n_pop;
        @(posedge clk);
        #1;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_outputs", 64'({bus.sum, bus.c_out, bus.ovf, bus.zero}), 64'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("flush_no_ghost", 64'(bus.out_valid), 64'd0);
        send(mk(32'h0000_0042, 32'h0000_0001, 1'b0, 1'b1));
        drain();
        chk("flush_pops", 64'(n_pop - n0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
